// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, word type and parameter checks for the asymmetric FIFO read side
package fifo_pkg;

    localparam int DSIZE_DEF = 32;
    localparam int OSIZE_DEF = 8;

    typedef logic [DSIZE_DEF-1:0] data_t;

    // A word must split into a whole number of beats
    function automatic bit ratio_ok(input int dsize, input int osize);
        return (osize > 0) && (dsize % osize == 0);
    endfunction

endpackage

// File: rtl/word_buf2.sv
// word_buf2: two-entry word buffer with push/pop and occupancy count
module word_buf2
    import fifo_pkg::*;
#(
    parameter int W = DSIZE_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] mem_q [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;

    // Pointers toggle on each push/pop; count tracks the difference
    always_comb begin
        head_d = head_q ^ pop_i;
        tail_d = tail_q ^ push_i;
        cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Pointer and count registers, cleared on reset so buffered words are discarded
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Word storage carries no reset; the top gates its output while empty
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[tail_q] <= data_i;
    end

    assign head_o = mem_q[head_q];
    assign cnt_o  = cnt_q;

`ifndef SYNTHESIS
    // A capture into a full buffer without a same-cycle retire would drop a word
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && cnt_q == 2'd2))
        else $error("word_buf2: capture into full buffer");

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= 2'd2)
        else $error("word_buf2: count out of range");
`endif

endmodule

// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker: pops FIFO words and streams them as LSB-first narrow beats
module fifo_rd_unpacker
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int OSIZE = OSIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_fifo_rd,
    input  logic [DSIZE-1:0] i_fifo_rdata,
    input  logic             i_fifo_rempty,
    output logic [OSIZE-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast,
    output logic             o_busy
);

    localparam int            RATIO = DSIZE / OSIZE;
    localparam int            BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST  = BW'(RATIO - 1);

    if (!ratio_ok(DSIZE, OSIZE)) begin : g_bad_ratio
        $error("fifo_rd_unpacker: DSIZE must be a multiple of OSIZE");
    end

    logic             inflight_q, inflight_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [1:0]       cnt;
    logic [1:0]       occ;
    logic [DSIZE-1:0] head;
    logic             accept;
    logic             retire;

    // Registered read data lands one cycle after the pop, so the in-flight flag is the push
    word_buf2 #(.W(DSIZE)) u_buf (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .push_i (inflight_q),
        .data_i (i_fifo_rdata),
        .pop_i  (retire),
        .head_o (head),
        .cnt_o  (cnt)
    );

    // Stream handshake, refill decision (room counts the pop in flight) and beat sequencing
    always_comb begin
        o_tvalid   = cnt != 2'd0;
        accept     = o_tvalid & i_tready;
        retire     = accept & (beat_q == LAST);
        occ        = cnt + {1'b0, inflight_q};
        o_fifo_rd  = !i_fifo_rempty & ((occ < 2'd2) | ((occ == 2'd2) & retire));
        inflight_d = o_fifo_rd;
        beat_d     = accept ? (retire ? '0 : beat_q + 1'b1) : beat_q;
        o_tlast    = o_tvalid & (beat_q == LAST);
        o_tdata    = o_tvalid ? head[beat_q*OSIZE +: OSIZE] : '0;
        o_busy     = o_tvalid | inflight_q;
    end

    // Reset drops any pop in flight and restarts at the first slice
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
        end
    end

endmodule
